pad_button_conditioner: RTL and testbench
=========================================

// Module: pad_button_conditioner
// PURPOSE
//  Conditions raw launchpad pad buttons before the LED event generators.
//  Per channel: 2-flop synchroniser, debounce counter, press/release pulses.
//  The debounced level feeds each event block's button input.
//  A registered priority encoder reports the lowest pressed-edge index to the event selector.
// PARAMETERS
//  N_BUTTONS        8    number of independent pad channels (1..16)
//  DEBOUNCE_CYCLES  16   consecutive disagreeing sync samples needed to flip (>=2)
//  ID_W             3    width of press_id; must satisfy 2**ID_W >= N_BUTTONS
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  rst          in   1          asynchronous, active-low reset
//  btn_raw      in   N_BUTTONS  raw asynchronous pad inputs, 1 = pressed
//  btn_level    out  N_BUTTONS  debounced level per channel (to event button inputs)
//  btn_press    out  N_BUTTONS  1-cycle pulse on debounced 0->1
//  btn_release  out  N_BUTTONS  1-cycle pulse on debounced 1->0
//  press_valid  out  1          1 when any btn_press bit was set on the previous edge
//  press_id     out  ID_W       lowest index among those press pulses; 0 when !press_valid
// BEHAVIOUR
//  Reset (rst=0, async): sync flops, counters, btn_level, btn_press, btn_release,
//   press_valid and press_id all go to 0 immediately. They stay 0 while rst=0.
//  Synchroniser: s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
//  Per-channel counter, width $clog2(DEBOUNCE_CYCLES):
//   - s2 == level: counter <= 0 (any glitch shorter than threshold is discarded).
//   - s2 != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
//   - s2 != level and counter == DEBOUNCE_CYCLES-1: level <= s2; counter <= 0;
//     pulse btn_press (s2=1) or btn_release (s2=0) for exactly one cycle.
//  Latency: let edge 0 be the first edge that samples btn_raw=1, with btn_raw held high.
//   btn_level and btn_press rise after edge DEBOUNCE_CYCLES+1.
//   Release latency is identical.
//  Two-state view per channel: STABLE_LO / STABLE_HI. The counter is the pending-change qualifier.
//   No other states exist.
//  Pulse rules:
//   - A press and a release are never both set in the same channel in the same cycle.
//   - A pulse never repeats while the level is held.
//  Channels are fully independent; simultaneous presses on several channels all pulse together.
//  Encoder: press_valid and press_id are registered from btn_press, so they lag btn_press by 1 cycle.
//   When several bits are set, the lowest index wins.
//  Reset mid-count: the counter is lost. After rst deasserts with the button held,
//   the full sync+debounce latency applies again and btn_press fires.
//  Counter saturation is impossible by construction; no wrap-around.
// STRUCTURE
//  Shared package pad_pkg: N_PADS_DEFAULT=8, DEBOUNCE_DEFAULT=16 and the pad-index type width.
//   The event blocks use the same constants.
//  Sub-module pad_debounce_ch: one channel (sync, counter, level, press, release),
//   instantiated N_BUTTONS times via generate.
//  Top level: the generate loop plus the registered lowest-index priority encoder.
// TESTING
//  1 Reset: rst=0 with btn_raw=all 1s -> all outputs 0. Release rst with button held ->
//    btn_level[k]=1 after DEBOUNCE_CYCLES+2 edges, one btn_press[k] pulse.
//  2 Clean press on ch3, D=16: btn_level[3] rises after edge 17, btn_press[3] high 1 cycle,
//    press_valid=1 and press_id=3 on the next cycle.
//  3 Bounce: 15-cycle high glitch on ch0, then low -> no level change, no pulses.
//    A 16-cycle glitch -> press, then release 17+ cycles after it drops.
//  4 Simultaneous: ch2 and ch5 rise on the same edge -> both btn_press bits pulse together,
//    press_id=2.
//  5 Mid-operation reset: assert rst at count 10 on ch1 -> outputs 0 immediately.
//    Deassert with ch1 held -> full latency, single press pulse.
//  6 Hold 1000 cycles then release -> exactly one press and one release.
//    btn_level held high throughout the hold window.

Source files
------------

// File: rtl/pad_pkg.sv
// Constants and types shared by the pad button conditioner and the LED event blocks.
package pad_pkg;

    localparam int N_PADS_DEFAULT   = 8;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int PAD_ID_W         = 3;

    typedef logic [PAD_ID_W-1:0] pad_idx_t;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } pad_state_e;

endpackage

// File: rtl/pad_debounce_ch.sv
// One pad channel: two-flop synchroniser, debounce counter, debounced level
// and single-cycle press/release pulses.
module pad_debounce_ch
    import pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    pad_state_e    r_state;
    pad_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_press;
    logic          r_release;
    logic          w_press_next;
    logic          w_release_next;
    logic          w_disagree;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= STABLE_LO;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    assign w_disagree = r_sync2 != (r_state == STABLE_HI);

    // Any agreeing sample clears the pending count, so short glitches never accumulate.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = '0;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        if (w_disagree) begin
            if (r_cnt == CNT_LAST) begin
                w_state_next   = r_sync2 ? STABLE_HI : STABLE_LO;
                w_press_next   = r_sync2;
                w_release_next = !r_sync2;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = (r_state == STABLE_HI);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/pad_button_conditioner.sv
// Array of debounced pad channels plus a registered lowest-index encoder of
// the press pulses for the event selector.
module pad_button_conditioner
    import pad_pkg::*;
#(
    parameter int N_BUTTONS       = N_PADS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int ID_W            = PAD_ID_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_BUTTONS-1:0] i_btn_raw,
    output logic [N_BUTTONS-1:0] o_btn_level,
    output logic [N_BUTTONS-1:0] o_btn_press,
    output logic [N_BUTTONS-1:0] o_btn_release,
    output logic                 o_press_valid,
    output logic [ID_W-1:0]      o_press_id
);

    logic [N_BUTTONS-1:0] w_level;
    logic [N_BUTTONS-1:0] w_press;
    logic [N_BUTTONS-1:0] w_release;
    logic [ID_W-1:0]      w_id_next;
    logic                 r_press_valid;
    logic [ID_W-1:0]      r_press_id;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
        pad_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_raw     (i_btn_raw[gi]),
            .o_level   (w_level[gi]),
            .o_press   (w_press[gi]),
            .o_release (w_release[gi])
        );
    end

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        w_id_next = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_id_next = ID_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press_valid <= 1'b0;
            r_press_id    <= '0;
        end else begin
            r_press_valid <= |w_press;
            r_press_id    <= w_id_next;
        end
    end

    assign o_btn_level   = w_level;
    assign o_btn_press   = w_press;
    assign o_btn_release = w_release;
    assign o_press_valid = r_press_valid;
    assign o_press_id    = r_press_id;

endmodule

// File: tb/tb_pad_button_conditioner.sv
// Scenario bench for pad_button_conditioner with a window-based reference model.
module tb_pad_button_conditioner;

    localparam int N    = 8;
    localparam int D    = 16;
    localparam int IDW  = 3;
    localparam int MAXE = 16384;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn_raw = '0;
    logic [N-1:0]   btn_level;
    logic [N-1:0]   btn_press;
    logic [N-1:0]   btn_release;
    logic           press_valid;
    logic [IDW-1:0] press_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pad_button_conditioner #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .ID_W            (IDW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn_raw     (btn_raw),
        .o_btn_level   (btn_level),
        .o_btn_press   (btn_press),
        .o_btn_release (btn_release),
        .o_press_valid (press_valid),
        .o_press_id    (press_id)
    );

    // Reference model: a channel flips when the last D synchronised samples
    // all disagree with its level. The sample used at post-reset edge e is
    // btn_raw from edge e-2 (zero for the first two edges after reset).
    logic [N-1:0]   raw_hist [MAXE];
    int             m_e;
    logic [N-1:0]   m_level, m_press, m_release;
    logic           m_pv;
    logic [IDW-1:0] m_pid;

    function automatic logic flips(int k, int e, logic lvl);
        // windows reaching the zero samples right after reset cannot disagree with level 0
        if (e - D + 1 < 2) return 1'b0;
        for (int j = e - D + 1; j <= e; j++) begin
            if (raw_hist[(j - 2) % MAXE][k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [IDW-1:0] lowest(logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return IDW'(i);
        end
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e       <= 0;
            m_level   <= '0;
            m_press   <= '0;
            m_release <= '0;
            m_pv      <= 1'b0;
            m_pid     <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (flips(k, m_e, m_level[k])) begin
                    m_level[k]   <= ~m_level[k];
                    m_press[k]   <= ~m_level[k];
                    m_release[k] <= m_level[k];
                end else begin
                    m_press[k]   <= 1'b0;
                    m_release[k] <= 1'b0;
                end
            end
            m_pv                  <= |m_press;
            m_pid                 <= lowest(m_press);
            raw_hist[m_e % MAXE]  <= btn_raw;
            m_e                   <= m_e + 1;
        end
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({btn_level, btn_press, btn_release, press_valid, press_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got lvl=%h prs=%h rel=%h pv=%b id=%0d, want all 0",
                     btn_level, btn_press, btn_release, press_valid, press_id);
        end
        rst_n = 1'b1;
        for (int i = 0; i <= D + 3; i++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== ((i >= D + 1) ? {N{1'b1}} : {N{1'b0}}) ||
                btn_press !== ((i == D + 1) ? {N{1'b1}} : {N{1'b0}})) begin
                errors++;
                $display("FAIL reset_release edge %0d: got lvl=%h prs=%h, want lvl=%h prs=%h", i,
                         btn_level, btn_press, (i >= D + 1) ? {N{1'b1}} : {N{1'b0}},
                         (i == D + 1) ? {N{1'b1}} : {N{1'b0}});
            end
        end
        btn_raw = '0;
        repeat (D + 4) @(negedge clk);
        checks++;
        if (btn_level !== '0) begin
            errors++;
            $display("FAIL reset_drop: got lvl=%h, want 0", btn_level);
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 8'b0000_1000;
        for (int i = 0; i <= D + 3; i++) begin
            @(negedge clk);
            checks++;
            if (btn_level[3] !== (i >= D + 1) || btn_press !== ((i == D + 1) ? 8'h08 : 8'h00)) begin
                errors++;
                $display("FAIL clean_press edge %0d: got lvl3=%b prs=%h, want lvl3=%b prs=%h", i,
                         btn_level[3], btn_press, (i >= D + 1), (i == D + 1) ? 8'h08 : 8'h00);
            end
            checks++;
            if (press_valid !== (i == D + 2) || press_id !== ((i == D + 2) ? 3'd3 : 3'd0)) begin
                errors++;
                $display("FAIL clean_encoder edge %0d: got pv=%b id=%0d, want pv=%b id=%0d", i,
                         press_valid, press_id, (i == D + 2), (i == D + 2) ? 3 : 0);
            end
        end
        btn_raw = '0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_bounce();
        int np, nr, pe, re, hi;
        hi = 0; np = 0;
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == D - 2) btn_raw[0] = 1'b0;
            if (btn_level[0] || btn_press[0]) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL bounce_short: got %0d active cycles, want 0", hi);
        end
        np = 0; nr = 0; pe = -1; re = -1;
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == D - 1) btn_raw[0] = 1'b0;
            if (btn_press[0]) begin np++; pe = i; end
            if (btn_release[0]) begin nr++; re = i; end
        end
        checks++;
        if (np !== 1 || pe !== D + 1) begin
            errors++;
            $display("FAIL bounce_long_press: got %0d pulses at edge %0d, want 1 at %0d", np, pe, D + 1);
        end
        checks++;
        if (nr !== 1 || re !== D + D + 1) begin
            errors++;
            $display("FAIL bounce_long_release: got %0d pulses at edge %0d, want 1 at %0d", nr, re, 2 * D + 1);
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 8'b0010_0100;
        for (int i = 0; i <= D + 3; i++) begin
            @(negedge clk);
            if (i == D + 1) begin
                checks++;
                if (btn_press !== 8'h24 || btn_level !== 8'h24) begin
                    errors++;
                    $display("FAIL simul_press: got prs=%h lvl=%h, want 24/24", btn_press, btn_level);
                end
            end
            if (i == D + 2) begin
                checks++;
                if (press_valid !== 1'b1 || press_id !== 3'd2) begin
                    errors++;
                    $display("FAIL simul_encoder: got pv=%b id=%0d, want pv=1 id=2", press_valid, press_id);
                end
            end
        end
        btn_raw = '0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int np;
        btn_raw[7] = 1'b1;
        repeat (D + 4) @(negedge clk);
        checks++;
        if (btn_level !== 8'h80) begin
            errors++;
            $display("FAIL midrst_setup: got lvl=%h, want 80", btn_level);
        end
        btn_raw[1] = 1'b1;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, press_valid, press_id} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got lvl=%h prs=%h rel=%h pv=%b id=%0d, want all 0",
                     btn_level, btn_press, btn_release, press_valid, press_id);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (btn_level !== '0) begin
            errors++;
            $display("FAIL midrst_hold: got lvl=%h, want 0", btn_level);
        end
        rst_n = 1'b1;
        np = 0;
        for (int i = 0; i <= D + 3; i++) begin
            @(negedge clk);
            if (btn_press[1]) np++;
            checks++;
            if (btn_level !== ((i >= D + 1) ? 8'h82 : 8'h00)) begin
                errors++;
                $display("FAIL midrst_relatch edge %0d: got lvl=%h, want %h", i, btn_level,
                         (i >= D + 1) ? 8'h82 : 8'h00);
            end
        end
        checks++;
        if (np !== 1) begin
            errors++;
            $display("FAIL midrst_pulses: got %0d ch1 presses, want 1", np);
        end
        btn_raw = '0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_hold();
        int np, nr, gaps;
        np = 0; nr = 0; gaps = 0;
        btn_raw[4] = 1'b1;
        for (int i = 0; i < 1000 + D + 10; i++) begin
            @(negedge clk);
            if (i == 999) btn_raw[4] = 1'b0;
            if (btn_press[4]) np++;
            if (btn_release[4]) nr++;
            if (i >= D + 1 && i <= 1000 + D && !btn_level[4]) gaps++;
        end
        checks++;
        if (np !== 1 || nr !== 1) begin
            errors++;
            $display("FAIL hold_pulses: got %0d presses %0d releases, want 1 and 1", np, nr);
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL hold_level: got %0d low cycles in hold window, want 0", gaps);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release ||
                press_valid !== m_pv || press_id !== m_pid) begin
                errors++;
                $display("FAIL random cyc %0d: got lvl=%h prs=%h rel=%h pv=%b id=%0d, want %h %h %h %b %0d",
                         c, btn_level, btn_press, btn_release, press_valid, press_id,
                         m_level, m_press, m_release, m_pv, m_pid);
            end
            bad = int'(|(btn_press & btn_release));
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL random_exclusive cyc %0d: got prs=%h rel=%h overlapping, want none", c,
                         btn_press, btn_release);
            end
            rst_n = !(c >= 1500 && c < 1503);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 27) == 0) btn_raw[k] = ~btn_raw[k];
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_mid_reset();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
